// File: rtl/delta_counter.sv
// delta_counter: wrapping up/down accumulator stepping by a programmable
// delta once per clock, plus a registered copy of the last step applied.
// Both outputs come directly from flops; reset clears them asynchronously.
module delta_counter #(
    parameter int WIDTH   = 4,
    parameter int DELTA_W = 3
) (
    input  logic               clk,
    input  logic               resetn,     // active-high, asynchronous
    input  logic [DELTA_W-1:0] delta,
    input  logic               direction,  // 0 = up, 1 = down
    output logic [WIDTH-1:0]   count,
    output logic [WIDTH-1:0]   current
);

    logic [WIDTH-1:0] delta_ext;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] current_reg;
    logic [WIDTH-1:0] current_next;

    // Zero-extend the step to the accumulator width, bit by bit, so the
    // arithmetic below is done entirely at WIDTH bits.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_ext
            if (gi < DELTA_W) begin : g_copy
                assign delta_ext[gi] = delta[gi];
            end else begin : g_zero
                assign delta_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // Next-state: add or subtract the step; carry/borrow falls off the top
    // so the counter wraps modulo 2^WIDTH.
    always_comb begin
        current_next = delta_ext;
        if (direction) begin
            count_next = count_reg - delta_ext;
        end else begin
            count_next = count_reg + delta_ext;
        end
    end

    // State registers: reset dominates any coincident clock edge.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            count_reg   <= '0;
            current_reg <= '0;
        end else begin
            count_reg   <= count_next;
            current_reg <= current_next;
        end
    end

    assign count   = count_reg;
    assign current = current_reg;

endmodule

// File: tb/tb_delta_counter.sv
// Directed testbench for delta_counter. An integer-arithmetic model tracks
// the expected outputs; a negedge process compares every cycle, and the
// directed sequences also pin both DUT and model to hand-computed values.
module tb_delta_counter;

    logic       clk;
    logic       resetn;
    logic [2:0] delta;
    logic       direction;
    logic [3:0] count;
    logic [3:0] current;

    int n_vec;
    int n_bad;
    int m_count;
    int m_current;
    bit cmp_en;

    delta_counter #(.WIDTH(4), .DELTA_W(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .delta     (delta),
        .direction (direction),
        .count     (count),
        .current   (current)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock with reset released: drive inputs after the falling edge,
    // advance the model after the rising edge, then pin DUT and model.
    task automatic step(input int d, input int dir, input int exp_count);
        @(negedge clk);
        resetn    = 1'b0;
        delta     = 3'(d);
        direction = dir[0];
        @(posedge clk);
        #1;
        m_current = d;
        if (dir == 0) m_count = (m_count + d) % 16;
        else          m_count = (m_count - d + 16) % 16;
        $display("step delta=%0d dir=%0d -> count=%0d current=%0d (exp %0d)",
                 d, dir, count, current, exp_count);
        check("lit_count", int'(count), exp_count);
        check("lit_current", int'(current), d);
        check("model_count", m_count, exp_count);
    endtask

    // Assert reset between edges and confirm outputs clear before any edge.
    task automatic pulse_reset(input int edges);
        @(negedge clk);
        #2;
        resetn = 1'b1;
        #1;
        m_count   = 0;
        m_current = 0;
        $display("reset asserted -> count=%0d current=%0d", count, current);
        check("rst_async_count", int'(count), 0);
        check("rst_async_current", int'(current), 0);
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_count", int'(count), 0);
            check("rst_hold_current", int'(current), 0);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_count", int'(count), m_count);
            check("cmp_current", int'(current), m_current);
        end
    end

    initial begin
        int up_exp[7];
        n_vec     = 0;
        n_bad     = 0;
        m_count   = 0;
        m_current = 0;
        cmp_en    = 1'b0;
        resetn    = 1'b1;
        delta     = 3'd5;
        direction = 1'b0;

        // Reset held for three edges with delta=5.
        #1;
        check("reset_count", int'(count), 0);
        check("reset_current", int'(current), 0);
        cmp_en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst3_count", int'(count), 0);
        end
        step(5, 0, 5);

        // Up-count with wrap.
        pulse_reset(1);
        up_exp = '{3, 6, 9, 12, 15, 2, 5};
        for (int i = 0; i < 7; i++) step(3, 0, up_exp[i]);

        // Step-size changes.
        pulse_reset(1);
        step(3, 0, 3);
        step(3, 0, 6);
        step(7, 0, 13);
        step(7, 0, 4);
        step(2, 0, 6);
        step(2, 0, 8);

        // Down-count with borrow, then reverse.
        pulse_reset(1);
        step(2, 1, 14);
        step(2, 1, 12);
        step(2, 1, 10);
        step(2, 0, 12);

        // Hold with delta=0, alternating direction.
        pulse_reset(1);
        step(3, 0, 3);
        step(3, 0, 6);
        step(3, 0, 9);
        for (int i = 0; i < 5; i++) step(0, i % 2, 9);

        // Boundary wraps: 15+1 -> 0 and 0-1 -> 15.
        pulse_reset(1);
        step(7, 0, 7);
        step(7, 0, 14);
        step(1, 0, 15);
        step(1, 0, 0);
        step(1, 1, 15);
        step(7, 1, 8);

        // Mid-operation reset at count=11, then restart from 0.
        pulse_reset(1);
        step(3, 0, 3);
        step(3, 0, 6);
        step(3, 0, 9);
        step(2, 0, 11);
        pulse_reset(2);
        step(4, 0, 4);
        step(6, 1, 14);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/delta_counter.md
# delta_counter

Ladder step counter: a 4-bit accumulator that climbs or descends by a programmable step size (`delta`, 0–7) once per clock. It also reports the step size applied on the most recent update. It is the core counting element of the ladder counter: upstream control logic supplies step size and direction, and downstream logic consumes `count` and `current`.

## Interface
Parameters:
- `WIDTH`, default 4: width of `count` and `current`.
- `DELTA_W`, default 3: width of `delta`. Must satisfy `DELTA_W` <= `WIDTH`.

Ports:
- `clk`, input, 1: single clock. All state updates occur on the rising edge.
- `resetn`, input, 1: reset, asynchronous and active-high. The name is kept per codebase convention; the polarity is high.
- `delta`, input, `DELTA_W`: step size. Sampled every rising edge.
- `direction`, input, 1: 0 = count up, 1 = count down. Sampled every rising edge.
- `count`, output, `WIDTH`: registered accumulator value.
- `current`, output, `WIDTH`: registered, zero-extended copy of the `delta` applied at the last update.

## Operation
- Reset (`resetn`=1): `count`=0 and `current`=0 immediately, without waiting for a clock edge. Both outputs hold 0 for as long as `resetn` stays high.
- Each rising edge with `resetn`=0:
  - `current` <= zero-extend(`delta`).
  - If `direction`=0: `count` <= (`count` + `delta`) mod 2^`WIDTH`.
  - If `direction`=1: `count` <= (`count` − `delta`) mod 2^`WIDTH`.
- Arithmetic: `delta` is zero-extended to `WIDTH` bits. The add or subtract is computed at `WIDTH` bits, and the carry or borrow is discarded, so the counter wraps.
  - Up, 15 + 1 → 0.
  - Down, 0 − 1 → 15.
- `delta`=0: `count` holds its value and `current` becomes 0, regardless of `direction`.
- `delta` or `direction` changes: the new value takes effect at the next rising edge. No internal history is kept beyond the `count` and `current` registers.
- No other state, no FSM, and no handshake. The block is always enabled when out of reset.
- Outputs come straight from flip-flops, with no combinational path from inputs to outputs.

## Timing
- Latency: an input sampled at edge N is visible on `count` and `current` immediately after edge N, so one register stage.
- Throughput: one update per clock, with no stalls.
- Reset assertion: asynchronous. Outputs go to 0 within the flop clear-to-Q delay, including mid-count.
- Reset deassertion:
  - Must be synchronous to `clk`; the integrating level provides this.
  - The first update occurs at the first rising edge at which `resetn` is sampled low.
- Simultaneous reset and clock edge: reset wins, and outputs stay 0.
- Inputs must meet setup/hold to `clk`. Changes between edges have no effect until the next edge.

## Test plan
- Reset: hold `resetn`=1 for 3 edges with `delta`=5 → `count`=0 and `current`=0 throughout. Release → first edge with `delta`=5, `direction`=0 gives `count`=5, `current`=5.
- Up-count with wrap: from 0, `delta`=3, `direction`=0 → `count` 3, 6, 9, 12, 15, 2, 5 on successive edges; `current`=3 each cycle.
- Step change: after `count` reaches 6 with `delta`=3, switch to `delta`=7 → next values 13, 4 (wrap); `current`=7. Then `delta`=2 → 6, 8.
- Down-count with borrow: from 0, `delta`=2, `direction`=1 → `count` 14, 12, 10. Then switch `direction` to 0 → 12.
- Hold: from `count`=9, set `delta`=0 → `count` stays 9 over 5 edges with either `direction`; `current`=0.
- Mid-operation reset: while `count`=11, pulse `resetn` high between edges → `count` and `current` drop to 0 before the next edge. After release, counting restarts from 0.
